// File: rtl/mem_arb_pkg.sv
// Shared types for the sprite/pattern RAM arbiter: read-return tag and
// burst counter width.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_H    = 2'd1,
    TAG_L    = 2'd2
  } rd_tag_t;

  localparam int BURST_CNT_BITS = 8;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port arbiter for the single-port, one-cycle-latency pattern RAM:
// display port H has priority, a consecutive-grant limit protects port L.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_BITS = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 h_req,
  input  logic                 h_we,
  input  logic [ADDR_BITS-1:0] h_addr,
  input  logic [WORD_SIZE-1:0] h_wdata,
  output logic                 h_gnt,
  output logic                 h_rvalid,
  output logic [WORD_SIZE-1:0] h_rdata,
  input  logic                 l_req,
  input  logic                 l_we,
  input  logic [ADDR_BITS-1:0] l_addr,
  input  logic [WORD_SIZE-1:0] l_wdata,
  output logic                 l_gnt,
  output logic                 l_rvalid,
  output logic [WORD_SIZE-1:0] l_rdata,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata
);

  localparam logic [BURST_CNT_BITS-1:0] BURST_LIMIT = BURST_CNT_BITS'(MAX_BURST);

  logic [BURST_CNT_BITS-1:0] burst_cnt_reg, burst_cnt_next;
  rd_tag_t                   tag_reg, tag_next;
  logic                      limit_hit;

  assign limit_hit = (burst_cnt_reg == BURST_LIMIT);

  // Grants are held off entirely while reset is asserted.
  always_comb begin
    h_gnt = 1'b0;
    l_gnt = 1'b0;
    if (reset_n) begin
      if (h_req && (!l_req || !limit_hit)) begin
        h_gnt = 1'b1;
      end else if (l_req) begin
        l_gnt = 1'b1;
      end
    end
  end

  // Counts H grants that L had to sit through; any gap in l_req restarts it.
  always_comb begin
    burst_cnt_next = burst_cnt_reg;
    if (!l_req || l_gnt) begin
      burst_cnt_next = '0;
    end else if (h_gnt && !limit_hit) begin
      burst_cnt_next = burst_cnt_reg + BURST_CNT_BITS'(1);
    end
  end

  always_comb begin
    tag_next = TAG_NONE;
    if (h_gnt && !h_we) begin
      tag_next = TAG_H;
    end else if (l_gnt && !l_we) begin
      tag_next = TAG_L;
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (h_gnt) begin
      mem_we    = h_we;
      mem_addr  = h_addr;
      mem_wdata = h_wdata;
    end else if (l_gnt) begin
      mem_we    = l_we;
      mem_addr  = l_addr;
      mem_wdata = l_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      burst_cnt_reg <= '0;
      tag_reg       <= TAG_NONE;
    end else begin
      burst_cnt_reg <= burst_cnt_next;
      tag_reg       <= tag_next;
    end
  end

  assign h_rvalid = (tag_reg == TAG_H);
  assign l_rvalid = (tag_reg == TAG_L);
  assign h_rdata  = h_rvalid ? mem_rdata : '0;
  assign l_rdata  = l_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural registered-read RAM.
module tb_mem_arbiter;

  localparam int WS = 16;
  localparam int AB = 4;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          h_req, h_we, l_req, l_we;
  logic [AB-1:0] h_addr, l_addr;
  logic [WS-1:0] h_wdata, l_wdata;
  logic          h_gnt, h_rvalid, l_gnt, l_rvalid, mem_we;
  logic [WS-1:0] h_rdata, l_rdata, mem_wdata, mem_rdata;
  logic [AB-1:0] mem_addr;

  typedef struct {
    logic [WS-1:0] data;
    int            due;
  } exp_t;

  exp_t          h_q[$];
  exp_t          l_q[$];
  exp_t          e_h, e_l;
  logic [WS-1:0] model_mem [16];
  logic [WS-1:0] ram [16];
  int            n_cmp = 0;
  int            n_fail = 0;
  int            cyc = 0;

  mem_arbiter #(.WORD_SIZE(WS), .ADDR_BITS(AB), .MAX_BURST(MB)) dut (
    .clk(clk), .reset_n(reset_n),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Read-return monitor: pops the scoreboard whenever a port reports rvalid.
  always @(posedge clk) begin
    #3;
    if (h_rvalid === 1'b1) begin
      n_cmp++;
      if (h_q.size() == 0) begin
        n_fail++;
        $display("FAIL h_read: rvalid=1 data=%h at cycle %0d, required no read return", h_rdata, cyc);
      end else begin
        e_h = h_q.pop_front();
        if (h_rdata !== e_h.data || e_h.due != cyc) begin
          n_fail++;
          $display("FAIL h_read: data=%h cycle=%0d, required data=%h cycle=%0d", h_rdata, cyc, e_h.data, e_h.due);
        end else begin
          $display("h read return data=%h cycle=%0d", h_rdata, cyc);
        end
      end
    end else begin
      n_cmp++;
      if (h_rdata !== '0) begin
        n_fail++;
        $display("FAIL h_rdata_idle: rdata=%h, required 0000", h_rdata);
      end
      if (h_q.size() > 0 && h_q[0].due <= cyc) begin
        e_h = h_q.pop_front();
        n_fail++;
        $display("FAIL h_read_missing: rvalid=%b at cycle %0d, required 1 with data=%h", h_rvalid, cyc, e_h.data);
      end
    end
    if (l_rvalid === 1'b1) begin
      n_cmp++;
      if (l_q.size() == 0) begin
        n_fail++;
        $display("FAIL l_read: rvalid=1 data=%h at cycle %0d, required no read return", l_rdata, cyc);
      end else begin
        e_l = l_q.pop_front();
        if (l_rdata !== e_l.data || e_l.due != cyc) begin
          n_fail++;
          $display("FAIL l_read: data=%h cycle=%0d, required data=%h cycle=%0d", l_rdata, cyc, e_l.data, e_l.due);
        end else begin
          $display("l read return data=%h cycle=%0d", l_rdata, cyc);
        end
      end
    end else begin
      n_cmp++;
      if (l_rdata !== '0) begin
        n_fail++;
        $display("FAIL l_rdata_idle: rdata=%h, required 0000", l_rdata);
      end
      if (l_q.size() > 0 && l_q[0].due <= cyc) begin
        e_l = l_q.pop_front();
        n_fail++;
        $display("FAIL l_read_missing: rvalid=%b at cycle %0d, required 1 with data=%h", l_rvalid, cyc, e_l.data);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    h_req = 1'b0;
    l_req = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    h_req = 1'b1; h_we = 1'b1; h_addr = 4'd5; h_wdata = 16'h5555;
    l_req = 1'b1; l_we = 1'b0; l_addr = 4'd6; l_wdata = 16'h6666;
    next_cycle();
    next_cycle();
    #1;
    n_cmp++;
    if ({h_gnt, l_gnt, mem_we} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_gnt: h_gnt/l_gnt/mem_we=%b, required 000", {h_gnt, l_gnt, mem_we});
    end
    n_cmp++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      n_fail++;
      $display("FAIL reset_mem: addr=%h wdata=%h, required 0/0000", mem_addr, mem_wdata);
    end
    n_cmp++;
    if ({h_rvalid, l_rvalid} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_rvalid: h/l rvalid=%b, required 00", {h_rvalid, l_rvalid});
    end
    idle();
    reset_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_fill();
    logic [WS-1:0] wd;
    for (int i = 0; i < 16; i++) begin
      wd = 16'(16'hA000 + i * 16'h0111);
      h_req = 1'b1; h_we = 1'b1; h_addr = AB'(i); h_wdata = wd;
      l_req = 1'b0;
      #1;
      n_cmp++;
      if (h_gnt !== 1'b1 || l_gnt !== 1'b0 || mem_we !== 1'b1 || mem_addr !== AB'(i) || mem_wdata !== wd) begin
        n_fail++;
        $display("FAIL fill_write: gnt=%b%b we=%b addr=%h wdata=%h, required 10 1 %h %h",
                 h_gnt, l_gnt, mem_we, mem_addr, mem_wdata, AB'(i), wd);
      end
      model_mem[i] = wd;
      $display("h write addr=%h data=%h", AB'(i), wd);
      next_cycle();
    end
    idle();
    next_cycle();
  endtask

  task automatic test_single_l();
    l_req = 1'b1; l_we = 1'b1; l_addr = 4'd3; l_wdata = 16'hBEEF;
    #1;
    n_cmp++;
    if (l_gnt !== 1'b1 || h_gnt !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 4'd3 || mem_wdata !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL single_l_write: gnt=%b%b we=%b addr=%h wdata=%h, required 01 1 3 beef",
               h_gnt, l_gnt, mem_we, mem_addr, mem_wdata);
    end
    model_mem[3] = 16'hBEEF;
    $display("l write addr=3 data=beef");
    next_cycle();
    l_we = 1'b0;
    #1;
    n_cmp++;
    if (l_gnt !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 4'd3) begin
      n_fail++;
      $display("FAIL single_l_read: l_gnt=%b we=%b addr=%h, required 1 0 3", l_gnt, mem_we, mem_addr);
    end
    l_q.push_back('{data: model_mem[3], due: cyc + 1});
    next_cycle();
    idle();
    #1;
    n_cmp++;
    if (l_gnt !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
      n_fail++;
      $display("FAIL single_l_idle: l_gnt=%b we=%b addr=%h wdata=%h, required 0 0 0 0000",
               l_gnt, mem_we, mem_addr, mem_wdata);
    end
    next_cycle();
    n_cmp++;
    if (l_q.size() != 0 || h_q.size() != 0) begin
      n_fail++;
      $display("FAIL single_l_drain: pending h=%0d l=%0d, required 0 0", h_q.size(), l_q.size());
    end
  endtask

  task automatic test_same_cycle();
    h_req = 1'b1; h_we = 1'b1; h_addr = 4'd1; h_wdata = 16'h1111;
    next_cycle();
    model_mem[1] = 16'h1111;
    h_req = 1'b0;
    l_req = 1'b1; l_we = 1'b1; l_addr = 4'd2; l_wdata = 16'h2222;
    next_cycle();
    model_mem[2] = 16'h2222;
    h_req = 1'b1; h_we = 1'b0; h_addr = 4'd1;
    l_req = 1'b1; l_we = 1'b0; l_addr = 4'd2;
    #1;
    n_cmp++;
    if (h_gnt !== 1'b1 || l_gnt !== 1'b0 || mem_addr !== 4'd1) begin
      n_fail++;
      $display("FAIL same_cycle_h: gnt=%b%b addr=%h, required 10 1", h_gnt, l_gnt, mem_addr);
    end
    h_q.push_back('{data: model_mem[1], due: cyc + 1});
    next_cycle();
    h_req = 1'b0;
    #1;
    n_cmp++;
    if (l_gnt !== 1'b1 || h_gnt !== 1'b0 || mem_addr !== 4'd2) begin
      n_fail++;
      $display("FAIL same_cycle_l: gnt=%b%b addr=%h, required 01 2", h_gnt, l_gnt, mem_addr);
    end
    l_q.push_back('{data: model_mem[2], due: cyc + 1});
    next_cycle();
    idle();
    next_cycle();
    n_cmp++;
    if (l_q.size() != 0 || h_q.size() != 0) begin
      n_fail++;
      $display("FAIL same_cycle_drain: pending h=%0d l=%0d, required 0 0", h_q.size(), l_q.size());
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      h_req = 1'b1; h_we = 1'b0; h_addr = AB'(i);
      l_req = 1'b0;
      #1;
      n_cmp++;
      if (h_gnt !== 1'b1 || mem_addr !== AB'(i) || mem_we !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_grant: h_gnt=%b addr=%h we=%b, required 1 %h 0", h_gnt, mem_addr, mem_we, AB'(i));
      end
      h_q.push_back('{data: model_mem[i], due: cyc + 1});
      next_cycle();
    end
    idle();
    next_cycle();
    n_cmp++;
    if (h_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_drain: pending h=%0d, required 0", h_q.size());
    end
  endtask

  task automatic test_burst();
    int  hi = 0;
    int  la = 7;
    bit  exp_l;
    for (int i = 0; i < 15; i++) begin
      exp_l = ((i % (MB + 1)) == MB);
      h_req = 1'b1; h_we = 1'b0; h_addr = AB'(hi % 16);
      l_req = 1'b1; l_we = 1'b0; l_addr = AB'(la % 16);
      #1;
      n_cmp++;
      if (h_gnt !== !exp_l || l_gnt !== exp_l) begin
        n_fail++;
        $display("FAIL burst_seq[%0d]: h_gnt=%b l_gnt=%b, required %b %b", i, h_gnt, l_gnt, !exp_l, exp_l);
      end
      if (exp_l) begin
        l_q.push_back('{data: model_mem[la % 16], due: cyc + 1});
        la++;
      end else begin
        h_q.push_back('{data: model_mem[hi % 16], due: cyc + 1});
        hi++;
      end
      next_cycle();
    end
    idle();
    next_cycle();
    next_cycle();
    n_cmp++;
    if (l_q.size() != 0 || h_q.size() != 0) begin
      n_fail++;
      $display("FAIL burst_drain: pending h=%0d l=%0d, required 0 0", h_q.size(), l_q.size());
    end
  endtask

  task automatic test_lreq_pulse();
    int  hi = 2;
    bit  exp_l;
    for (int i = 0; i < 10; i++) begin
      exp_l = (i == 8);
      h_req = 1'b1; h_we = 1'b0; h_addr = AB'(hi % 16);
      l_req = (i != 3); l_we = 1'b0; l_addr = 4'd3;
      #1;
      n_cmp++;
      if (h_gnt !== !exp_l || l_gnt !== exp_l) begin
        n_fail++;
        $display("FAIL lreq_pulse[%0d]: h_gnt=%b l_gnt=%b, required %b %b", i, h_gnt, l_gnt, !exp_l, exp_l);
      end
      if (exp_l) begin
        l_q.push_back('{data: model_mem[3], due: cyc + 1});
      end else begin
        h_q.push_back('{data: model_mem[hi % 16], due: cyc + 1});
        hi++;
      end
      next_cycle();
    end
    idle();
    next_cycle();
    next_cycle();
    n_cmp++;
    if (l_q.size() != 0 || h_q.size() != 0) begin
      n_fail++;
      $display("FAIL lreq_pulse_drain: pending h=%0d l=%0d, required 0 0", h_q.size(), l_q.size());
    end
  endtask

  task automatic test_reset_mid_read();
    l_req = 1'b1; l_we = 1'b0; l_addr = 4'd3;
    #1;
    n_cmp++;
    if (l_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_grant: l_gnt=%b, required 1", l_gnt);
    end
    next_cycle();
    reset_n = 1'b0;
    h_req = 1'b1; h_we = 1'b1; h_addr = 4'd9; h_wdata = 16'h9999;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++;
      if ({h_gnt, l_gnt, mem_we, h_rvalid, l_rvalid} !== 5'b0 || mem_addr !== '0 || mem_wdata !== '0
          || h_rdata !== '0 || l_rdata !== '0) begin
        n_fail++;
        $display("FAIL rst_mid_outputs[%0d]: gnt=%b%b we=%b rvalid=%b%b addr=%h wdata=%h, required all 0",
                 i, h_gnt, l_gnt, mem_we, h_rvalid, l_rvalid, mem_addr, mem_wdata);
      end
      next_cycle();
    end
    idle();
    #1;
    reset_n = 1'b1;
    next_cycle();
    l_req = 1'b1; l_we = 1'b0; l_addr = 4'd3;
    #1;
    n_cmp++;
    if (l_gnt !== 1'b1 || mem_addr !== 4'd3) begin
      n_fail++;
      $display("FAIL rst_release_grant: l_gnt=%b addr=%h, required 1 3", l_gnt, mem_addr);
    end
    l_q.push_back('{data: model_mem[3], due: cyc + 1});
    next_cycle();
    idle();
    next_cycle();
    n_cmp++;
    if (l_q.size() != 0 || h_q.size() != 0) begin
      n_fail++;
      $display("FAIL rst_release_drain: pending h=%0d l=%0d, required 0 0", h_q.size(), l_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    h_req = 1'b0; h_we = 1'b0; h_addr = '0; h_wdata = '0;
    l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0;
    #1;
    test_reset();
    test_fill();
    test_single_l();
    test_same_cycle();
    test_back_to_back();
    test_burst();
    test_lreq_pulse();
    test_reset_mid_read();
    next_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
